// File: rtl/mem_access_unit_if.sv
// Bundle between the EX stage, the data memory and writeback
// for the memory-access stage.
interface mem_access_unit_if;
  logic        i_valid;
  logic        i_flush;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_is_unsigned_ld;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [31:0] i_pc;
  logic [4:0]  i_rd_addr;
  logic        i_reg_write_en;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_wmask;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic        o_wb_valid;
  logic [31:0] o_wb_pc;
  logic [4:0]  o_wb_rd_addr;
  logic        o_wb_reg_write_en;
  logic [31:0] o_wb_data;
  logic        o_wb_trap;

  modport slave (
    input  i_valid, i_flush, i_mem_read, i_mem_write,
    input  i_size, i_is_unsigned_ld, i_alu_result,
    input  i_store_data, i_pc, i_rd_addr, i_reg_write_en,
    input  i_dmem_ack, i_dmem_rdata,
    output o_dmem_req, o_dmem_we, o_dmem_addr,
    output o_dmem_wdata, o_dmem_wmask, o_stall,
    output o_wb_valid, o_wb_pc, o_wb_rd_addr,
    output o_wb_reg_write_en, o_wb_data, o_wb_trap
  );

  modport master (
    output i_valid, i_flush, i_mem_read, i_mem_write,
    output i_size, i_is_unsigned_ld, i_alu_result,
    output i_store_data, i_pc, i_rd_addr, i_reg_write_en,
    output i_dmem_ack, i_dmem_rdata,
    input  o_dmem_req, o_dmem_we, o_dmem_addr,
    input  o_dmem_wdata, o_dmem_wmask, o_stall,
    input  o_wb_valid, o_wb_pc, o_wb_rd_addr,
    input  o_wb_reg_write_en, o_wb_data, o_wb_trap
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues one data-memory
// transaction at a time and formats results for writeback.
module mem_access_unit (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, next_state;
  logic        kill;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        rwe_q;
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        ack;
  logic [1:0]  off;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  // Accept/misalignment decode for the incoming instruction
  always_comb begin
    off        = bus.i_alu_result[1:0];
    is_mem     = bus.i_mem_read | bus.i_mem_write;
    accept     = bus.i_valid & ~bus.i_flush & (state == IDLE);
    misaligned = (bus.i_size[1] & (off != 2'b00)) |
                 ((bus.i_size == 2'b01) & off[0]);
    ack        = (state == WAIT) & bus.i_dmem_ack;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state: aligned memory ops wait for the ack
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept && is_mem && !misaligned)
              next_state = WAIT;
      WAIT: if (ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs of the FSM plus store/load lane formatting
  always_comb begin
    bus.o_stall    = (state == WAIT);
    bus.o_dmem_req = (state == WAIT);
    st_data        = bus.i_store_data;
    st_mask        = 4'b1111;
    unique case (1'b1)
      bus.i_size == 2'b00: begin
        st_data = {4{bus.i_store_data[7:0]}};
        st_mask = 4'b0001 << off;
      end
      bus.i_size == 2'b01: begin
        st_data = {2{bus.i_store_data[15:0]}};
        st_mask = 4'b0011 << off;
      end
      default: ;
    endcase
    shifted = bus.i_dmem_rdata >> {off_q, 3'b000};
    ld_data = shifted;
    unique case (1'b1)
      size_q == 2'b00:
        ld_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      size_q == 2'b01:
        ld_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Registered dmem request fields and writeback results
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      kill                  <= 1'b0;
      size_q                <= 2'b00;
      off_q                 <= 2'b00;
      uns_q                 <= 1'b0;
      rwe_q                 <= 1'b0;
      bus.o_dmem_we         <= 1'b0;
      bus.o_dmem_addr       <= '0;
      bus.o_dmem_wdata      <= '0;
      bus.o_dmem_wmask      <= '0;
      bus.o_wb_valid        <= 1'b0;
      bus.o_wb_pc           <= '0;
      bus.o_wb_rd_addr      <= '0;
      bus.o_wb_reg_write_en <= 1'b0;
      bus.o_wb_data         <= '0;
      bus.o_wb_trap         <= 1'b0;
    end else begin
      bus.o_wb_valid        <= 1'b0;
      bus.o_wb_reg_write_en <= 1'b0;
      bus.o_wb_trap         <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          bus.o_wb_pc      <= bus.i_pc;
          bus.o_wb_rd_addr <= bus.i_rd_addr;
          if (!is_mem) begin
            bus.o_wb_valid        <= 1'b1;
            bus.o_wb_data         <= bus.i_alu_result;
            bus.o_wb_reg_write_en <= bus.i_reg_write_en;
          end else if (misaligned) begin
            bus.o_wb_valid <= 1'b1;
            bus.o_wb_trap  <= 1'b1;
            bus.o_wb_data  <= '0;
          end else begin
            kill             <= 1'b0;
            size_q           <= bus.i_size;
            off_q            <= off;
            uns_q            <= bus.i_is_unsigned_ld;
            rwe_q            <= bus.i_reg_write_en;
            bus.o_dmem_we    <= bus.i_mem_write;
            bus.o_dmem_addr  <= {bus.i_alu_result[31:2], 2'b00};
            bus.o_dmem_wdata <= st_data;
            bus.o_dmem_wmask <= bus.i_mem_write ? st_mask : 4'b0000;
          end
        end
      end else begin
        if (bus.i_flush) kill <= 1'b1;
        if (ack) begin
          kill                  <= 1'b0;
          bus.o_dmem_we         <= 1'b0;
          bus.o_dmem_wmask      <= 4'b0000;
          bus.o_wb_valid        <= ~(kill | bus.i_flush);
          bus.o_wb_reg_write_en <= ~(kill | bus.i_flush) &
                                   ~bus.o_dmem_we & rwe_q;
          bus.o_wb_data         <= bus.o_dmem_we ? '0 : ld_data;
        end
      end
    end
  end
endmodule
